gf180mcu_fd_sc_mcu9t5v0__invz_bus_arb4: RTL

GF180MCU_FD_SC_MCU9T5V0__INVZ_BUS_ARB4 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__invz_bus_arb4

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__invz_bus_arb4.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_bus_arb4.sv
// Round-robin arbiter enabling one of NREQ tristate drivers on a shared bus, with bounded tenure and turnaround gap.
// Optional registered KEEP output (bus keeper enable) under GF180MCU_FD_SC_MCU9T5V0__INVZ_BUS_ARB_KEEPER_EN.
//
// state | meaning
// IDLE  | no driver enabled, arbitrate among asserted requests each cycle
// GRANT | GNT[OWNER] enabled, hold counter tracks tenure length
// TURNA | all drivers off for TURN cycles; the last one arbitrates for the next tenure
module gf180mcu_fd_sc_mcu9t5v0__invz_bus_arb4 #(
  parameter int NREQ     = 4,
  parameter int TURN     = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [1:0]      OWNER,
  output logic            BUSY,
  inout  wire             VDD,
  inout  wire             VSS
`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_BUS_ARB_KEEPER_EN
  ,
  output logic            KEEP
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, TURNA} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [3:0]      hcnt_q, hcnt_d;
  logic [1:0]      tcnt_q, tcnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic [1:0]      sel;
  logic [NREQ-1:0] sel_oh;
  logic            any_req;
  logic            req_own;
  logic            arbitrate;
  int              off;
  int              best_off;

  // Power pins are connectivity only; nothing in the logic depends on them.
  wire unused_pwr = VDD ^ VSS;

  // Pick the asserted request with the smallest distance upward from ptr_q.
  always_comb begin
    sel      = ptr_q;
    best_off = NREQ;
    off      = 0;
    any_req  = |REQ;
    req_own  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i - int'(ptr_q) + NREQ) % NREQ;
      if (REQ[i] && off < best_off) begin
        best_off = off;
        sel      = 2'(i);
      end
      if (int'(owner_q) == i) req_own = REQ[i];
    end
    for (int i = 0; i < NREQ; i++) sel_oh[i] = (int'(sel) == i);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hcnt_d    = hcnt_q;
    tcnt_d    = tcnt_q;
    gnt_d     = gnt_q;
    arbitrate = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        arbitrate = 1'b1;
      end
      GRANT: begin
        if (req_own && hcnt_q < 4'(HOLD_MAX)) begin
          hcnt_d = hcnt_q + 4'd1;
        end else begin
          gnt_d   = '0;
          hcnt_d  = '0;
          tcnt_d  = 2'(TURN);
          state_d = TURNA;
        end
      end
      TURNA: begin
        gnt_d = '0;
        if (tcnt_q <= 2'd1) begin
          tcnt_d    = '0;
          state_d   = IDLE;
          arbitrate = 1'b1;
        end else begin
          tcnt_d = tcnt_q - 2'd1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Leaving TURNA counts as re-entering IDLE, so the gap between tenures is exactly TURN cycles.
    if (arbitrate && any_req) begin
      state_d = GRANT;
      gnt_d   = sel_oh;
      owner_d = sel;
      ptr_d   = (int'(sel) == NREQ - 1) ? 2'd0 : sel + 2'd1;
      hcnt_d  = 4'd1;
    end
    busy_d = |gnt_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_BUS_ARB_KEEPER_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) KEEP <= 1'b1;
    else     KEEP <= ~busy_d;
  end
`endif

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule
